// File: rtl/usi_pkg.sv
// usi_pkg: shared USI mode, error and UART state encodings plus parity helper
package usi_pkg;
  localparam logic [1:0] MODE_UART = 2'b00;
  localparam logic [1:0] MODE_I2C = 2'b01;
  localparam logic [1:0] MODE_SPI = 2'b10;
  typedef enum logic [1:0] {NONE, PARITY, FRAMING, TIMEOUT} usi_err_t;
  typedef enum logic [3:0] {
    IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP,
    RX_HUNT, RX_START, RX_DATA, RX_PARITY, RX_STOP, FINISH
  } uart_state_t;
  function automatic logic parity_bit(input logic [7:0] d, input logic odd);
    return ^d ^ odd;
  endfunction
endpackage

// File: rtl/usi_baud_counter.sv
// usi_baud_counter: reloadable bit-time down-counter with a one-shot tick at zero
module usi_baud_counter (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        load,
  input  logic        half,
  input  logic [15:0] div,
  output logic        tick
);
  logic [15:0] cnt;
  logic run;
  assign tick = run && cnt == 16'd0;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      cnt <= (half ? {1'b0, div[15:1]} : div) - 16'd1;
      run <= 1'b1;
    end else begin
      cnt <= cnt - {15'd0, cnt != 16'd0};
      run <= run && !tick;
    end
endmodule

// File: rtl/usi_uart_engine.sv
// usi_uart_engine: one-shot UART TX/RX frame engine with parity, framing and no-start timeout
module usi_uart_engine
  import usi_pkg::*;
#(
  parameter int RX_TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        uart_en,
  input  logic        dir,
  input  logic [15:0] baud_div,
  input  logic        parity_en,
  input  logic        parity_odd,
  input  logic [7:0]  tx_data,
  input  logic        rx,
  output logic        tx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        uart_done,
  output logic        uart_err,
  output logic [1:0]  err_code,
  output logic        busy
);
  uart_state_t state;
  usi_err_t err_q;
  logic en_q, par_en_q, odd_q, par_bad, rx_sync, start, load, half, tick;
  logic [1:0] rx_s;
  logic [15:0] div_q, div_sel;
  logic [7:0] dat;
  logic [2:0] idx;
  logic [31:0] tcnt, limit;
  assign rx_sync = rx_s[1];
  assign err_code = err_q;
  assign busy = state != IDLE;
  assign start = uart_en && !en_q && state == IDLE;
  assign limit = 32'(RX_TIMEOUT_BITS) * {16'd0, div_q};
  assign half = state == RX_HUNT;
  assign div_sel = state == IDLE ? baud_div : div_q;
  assign load = (start && dir) || (state == RX_HUNT && !rx_sync) ||
                (tick && (state inside {TX_START, TX_DATA, TX_PARITY, RX_DATA, RX_PARITY} ||
                          (state == RX_START && !rx_sync)));
  usi_baud_counter u_baud (
    .clk(clk), .n_rst(n_rst), .load(load), .half(half), .div(div_sel), .tick(tick)
  );
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      en_q <= 1'b1;
      rx_s <= 2'b11;
      tx <= 1'b1;
      rx_data <= '0;
      rx_valid <= 1'b0;
      uart_done <= 1'b0;
      uart_err <= 1'b0;
      err_q <= NONE;
      div_q <= '0;
      par_en_q <= 1'b0;
      odd_q <= 1'b0;
      par_bad <= 1'b0;
      dat <= '0;
      idx <= '0;
      tcnt <= '0;
    end else begin
      en_q <= uart_en;
      rx_s <= {rx_s[0], rx};
      rx_valid <= 1'b0;
      uart_done <= 1'b0;
      uart_err <= 1'b0;
      if (state != IDLE && !uart_en) begin
        state <= IDLE;
        tx <= 1'b1;
      end else
        case (state)
          IDLE: if (start) begin
            div_q <= baud_div;
            par_en_q <= parity_en;
            odd_q <= parity_odd;
            dat <= tx_data;
            idx <= '0;
            tcnt <= '0;
            par_bad <= 1'b0;
            if (baud_div < 16'd2) begin
              state <= FINISH;
              uart_err <= 1'b1;
              err_q <= TIMEOUT;
            end else if (dir) begin
              state <= TX_START;
              tx <= 1'b0;
            end else
              state <= RX_HUNT;
          end
          TX_START: if (tick) begin
            state <= TX_DATA;
            tx <= dat[0];
          end
          TX_DATA: if (tick) begin
            idx <= idx + 3'd1;
            tx <= idx == 3'd7 ? (par_en_q ? parity_bit(dat, odd_q) : 1'b1) : dat[idx + 3'd1];
            state <= idx == 3'd7 ? (par_en_q ? TX_PARITY : TX_STOP) : TX_DATA;
          end
          TX_PARITY: if (tick) begin
            state <= TX_STOP;
            tx <= 1'b1;
          end
          TX_STOP: if (tick) begin
            state <= FINISH;
            uart_done <= 1'b1;
          end
          RX_HUNT: if (tcnt == limit - 32'd1) begin
            state <= FINISH;
            uart_err <= 1'b1;
            err_q <= TIMEOUT;
          end else begin
            tcnt <= tcnt + 32'd1;
            if (!rx_sync) state <= RX_START;
          end
          // a start bit that is high again at mid-bit was a glitch; keep hunting
          RX_START: if (tick) state <= rx_sync ? RX_HUNT : RX_DATA;
          RX_DATA: if (tick) begin
            dat <= {rx_sync, dat[7:1]};
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= par_en_q ? RX_PARITY : RX_STOP;
          end
          RX_PARITY: if (tick) begin
            par_bad <= rx_sync != parity_bit(dat, odd_q);
            state <= RX_STOP;
          end
          RX_STOP: if (tick) begin
            state <= FINISH;
            rx_data <= dat;
            if (!rx_sync || par_bad) begin
              uart_err <= 1'b1;
              err_q <= rx_sync ? PARITY : FRAMING;
            end else begin
              uart_done <= 1'b1;
              rx_valid <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
    end
endmodule
